// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester memory port arbiter with one outstanding transaction
//
// Shares a single memory port between instruction fetch (if_*) and load/store (d_*).
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr -> if_gnt/if_rvalid/if_err/if_rdata   fetch requester
//   d_req/d_we/d_addr/d_wdata/d_be -> d_gnt/d_rvalid/d_err/d_rdata   data requester
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_ready, mem_rvalid/mem_rdata   memory side
//   spurious_rsp   sticky: response seen with nothing outstanding
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic                if_err,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                spurious_rsp
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             spurious_q, spurious_d;

  logic sel_data;
  logic any_req;
  logic issue;
  logic rsp;
  logic timeout;

  // Data wins only when fetch is idle or fetch owned the previous transaction.
  always_comb begin
    any_req  = if_req | d_req;
    sel_data = d_req & (~if_req | (last_owner_q == OWN_FETCH));
    issue    = (state_q == ST_IDLE) & any_req & mem_ready;
    rsp      = (state_q == ST_BUSY) & mem_rvalid;
    // A response in the final watchdog cycle takes precedence over the abort.
    timeout  = (state_q == ST_BUSY) & ~mem_rvalid & (count_q == CNT_W'(TIMEOUT - 1));
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DATA;
      last_owner_q <= OWN_DATA;
      count_q      <= '0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
      spurious_q   <= spurious_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    spurious_d   = spurious_q;
    case (state_q)
      ST_IDLE: begin
        spurious_d = spurious_q | mem_rvalid;
        if (issue) begin
          state_d      = ST_BUSY;
          owner_d      = sel_data;
          last_owner_d = sel_data;
          count_d      = '0;
        end
      end
      ST_BUSY: begin
        count_d = count_q + 1'b1;
        if (rsp || timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. Handshake pulses are gated by reset so they drop immediately on assertion.
  always_comb begin
    mem_req   = reset & any_req & (state_q == ST_IDLE);
    if_gnt    = reset & issue & ~sel_data;
    d_gnt     = reset & issue & sel_data;
    if_rvalid = reset & rsp & (owner_q == OWN_FETCH);
    d_rvalid  = reset & rsp & (owner_q == OWN_DATA);
    if_err    = reset & timeout & (owner_q == OWN_FETCH);
    d_err     = reset & timeout & (owner_q == OWN_DATA);
    mem_we    = sel_data & d_we;
    mem_addr  = sel_data ? d_addr : if_addr;
    mem_wdata = sel_data ? d_wdata : '0;
    mem_be    = sel_data ? d_be : '1;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    spurious_rsp = spurious_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid, if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt, d_rvalid, d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req, mem_ready, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              spurious_rsp;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic go_neg();
    @(negedge clk);
  endtask

  task automatic go_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    go_neg();
    go_next();
    rst_n = 1;
  endtask

  typedef struct packed {
    logic ir, dr, rdy, rv;
    logic eig, edg, eiv, edv, emr;
  } vec_t;

  vec_t tbl[14];

  // Behavioural reference: -1 = nothing outstanding, 0 = fetch, 1 = data.
  int   m_out, m_age, m_last;
  logic m_spur;

  initial begin
    int pos, errs, saw_rv;
    logic ip, dp;
    int rv_pct;

    // cycle-by-cycle table from reset: fetch only, contention, backpressure, spurious
    tbl[0]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};

    // reset state: outputs forced low even with every input active
    rst_n = 0;
    idle_inputs();
    #2;
    if_req = 1; d_req = 1; mem_ready = 1; mem_rvalid = 1;
    go_neg();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_gnts", {if_gnt, d_gnt}, 0);
    chk("rst_rvalids", {if_rvalid, d_rvalid}, 0);
    chk("rst_errs", {if_err, d_err}, 0);
    chk("rst_spurious", spurious_rsp, 0);
    go_next();
    idle_inputs();
    go_next();
    rst_n = 1;

    // table
    for (int i = 0; i < 14; i++) begin
      if_req = tbl[i].ir; if_addr = 32'h0;
      d_req = tbl[i].dr; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
      mem_ready = tbl[i].rdy; mem_rvalid = tbl[i].rv; mem_rdata = 32'h00500093;
      go_neg();
      chk($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].eig);
      chk($sformatf("tbl%0d_d_gnt", i), d_gnt, tbl[i].edg);
      chk($sformatf("tbl%0d_if_rvalid", i), if_rvalid, tbl[i].eiv);
      chk($sformatf("tbl%0d_d_rvalid", i), d_rvalid, tbl[i].edv);
      chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].emr);
      chk($sformatf("tbl%0d_errs", i), {if_err, d_err}, 0);
      if (tbl[i].eiv) chk($sformatf("tbl%0d_if_rdata", i), if_rdata, 32'h00500093);
      if (tbl[i].edg) begin
        chk($sformatf("tbl%0d_mem_we", i), mem_we, 1);
        chk($sformatf("tbl%0d_mem_addr", i), mem_addr, 32'h100);
        chk($sformatf("tbl%0d_mem_be", i), mem_be, 4'hF);
        chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, 32'hDEADBEEF);
      end
      if (tbl[i].eig) begin
        chk($sformatf("tbl%0d_fetch_we", i), mem_we, 0);
        chk($sformatf("tbl%0d_fetch_be", i), mem_be, 4'hF);
        chk($sformatf("tbl%0d_fetch_addr", i), mem_addr, 32'h0);
      end
      go_next();
    end
    idle_inputs();
    go_neg();
    chk("tbl_spurious_set", spurious_rsp, 1);
    go_next();

    // timeout: fetch never answered
    do_reset();
    if_req = 1; if_addr = 32'h40; mem_ready = 1;
    go_neg();
    chk("to_issue", if_gnt, 1);
    go_next();
    if_req = 0;
    pos = 0; errs = 0; saw_rv = 0;
    for (int k = 1; k <= 24; k++) begin
      go_neg();
      if (if_rvalid) saw_rv++;
      if (if_err) begin errs++; if (pos == 0) pos = k; end
      go_next();
    end
    chk("to_err_cycle", pos, TIMEOUT);
    chk("to_err_count", errs, 1);
    chk("to_no_rvalid", saw_rv, 0);
    mem_rvalid = 1;
    go_neg();
    chk("late_rsp_no_rvalid", {if_rvalid, d_rvalid}, 0);
    go_next();
    mem_rvalid = 0;
    go_neg();
    chk("late_rsp_spurious", spurious_rsp, 1);
    go_next();

    // tie: response in the last watchdog cycle
    do_reset();
    if_req = 1; mem_ready = 1;
    go_neg();
    chk("tie_issue", if_gnt, 1);
    go_next();
    if_req = 0;
    errs = 0;
    for (int k = 1; k < TIMEOUT; k++) begin
      go_neg();
      if (if_err || if_rvalid) errs++;
      go_next();
    end
    chk("tie_quiet_before", errs, 0);
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    go_neg();
    chk("tie_rvalid", if_rvalid, 1);
    chk("tie_err", if_err, 0);
    chk("tie_rdata", if_rdata, 32'h1234_5678);
    go_next();
    mem_rvalid = 0;
    go_neg();
    chk("tie_after_err", if_err, 0);
    chk("tie_spurious", spurious_rsp, 0);
    go_next();

    // reset during an outstanding load
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 1;
    go_neg();
    chk("mid_issue", d_gnt, 1);
    go_next();
    d_req = 0;
    rst_n = 0; mem_rvalid = 1;
    #1;
    chk("mid_pulses", {if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_req}, 0);
    go_neg();
    go_next();
    rst_n = 1; mem_rvalid = 0; if_req = 1; d_req = 1;
    go_neg();
    chk("mid_fetch_first", {if_gnt, d_gnt}, 2'b10);
    chk("mid_spurious", spurious_rsp, 0);
    go_next();

    // randomized run against the reference model
    do_reset();
    m_out = -1; m_age = 0; m_last = 1; m_spur = 0;
    ip = 0; dp = 0; rv_pct = 40;
    for (int c = 0; c < 3000; c++) begin
      int pick;
      logic e_mreq, e_ig, e_dg, e_iv, e_dv, e_ie, e_de;
      if (c % 250 == 0) rv_pct = (rv_pct == 40) ? 3 : 40;
      if (!ip) begin
        if_req = ($urandom_range(0, 99) < 50);
        if_addr = $urandom;
      end
      if (!dp) begin
        d_req = ($urandom_range(0, 99) < 50);
        d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom_range(0, 15));
      end
      ip = if_req; dp = d_req;
      mem_ready = ($urandom_range(0, 99) < 70);
      mem_rvalid = ($urandom_range(0, 99) < rv_pct);
      mem_rdata = $urandom;

      e_mreq = (m_out < 0) && (if_req || d_req);
      if (if_req && d_req) pick = (m_last == 1) ? 0 : 1;
      else pick = if_req ? 0 : 1;
      e_ig = e_mreq && mem_ready && pick == 0;
      e_dg = e_mreq && mem_ready && pick == 1;
      e_iv = (m_out == 0) && mem_rvalid;
      e_dv = (m_out == 1) && mem_rvalid;
      e_ie = (m_out == 0) && !mem_rvalid && (m_age + 1 == TIMEOUT);
      e_de = (m_out == 1) && !mem_rvalid && (m_age + 1 == TIMEOUT);

      go_neg();
      chk("rnd_mem_req", mem_req, e_mreq);
      chk("rnd_gnt", {if_gnt, d_gnt}, {e_ig, e_dg});
      chk("rnd_rvalid", {if_rvalid, d_rvalid}, {e_iv, e_dv});
      chk("rnd_err", {if_err, d_err}, {e_ie, e_de});
      chk("rnd_spurious", spurious_rsp, m_spur);
      if (e_mreq) begin
        chk("rnd_mem_addr", mem_addr, pick == 0 ? if_addr : d_addr);
        chk("rnd_mem_we", mem_we, pick == 0 ? 1'b0 : d_we);
        chk("rnd_mem_be", mem_be, pick == 0 ? 4'hF : d_be);
      end
      if (e_iv) chk("rnd_if_rdata", if_rdata, mem_rdata);
      if (e_dv) chk("rnd_d_rdata", d_rdata, mem_rdata);

      if (m_out < 0) begin
        if (mem_rvalid) m_spur = 1;
        if (e_ig || e_dg) begin m_out = pick; m_last = pick; m_age = 0; end
      end else if (mem_rvalid || e_ie || e_de) begin
        m_out = -1;
      end else begin
        m_age = m_age + 1;
      end
      if (e_ig) ip = 0;
      if (e_dg) dp = 0;
      go_next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
